// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: launch FSM encoding and size defaults.
package uart_pkg;

    localparam int BITLEN_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with registered level, full/empty status and a sticky overflow flag.
// DEPTH must be a power of two (>= 2) so the pointers wrap by plain binary overflow.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int BITLEN = BITLEN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [BITLEN-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [BITLEN-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic              overflow
);

    logic [BITLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = ovf_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push = wr_en & ~full;
    assign pop  = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage has no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of a UART transmitter: queues words and launches them one at a
// time, holding tx_data steady until the transmitter has finished the frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BITLEN = BITLEN_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic [BITLEN-1:0]      wr_data,
    input  logic                   wr_en,
    input  logic                   ovf_clr,
    input  logic                   tx_busy,
    output logic [BITLEN-1:0]      tx_data,
    output logic                   tx_data_ready,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    tx_state_e         state_q, state_d;
    logic [BITLEN-1:0] tx_data_q, tx_data_d;
    logic              rdy_q, rdy_d;
    logic              pop;
    logic [BITLEN-1:0] head;

    // Reset asserts immediately but releases two edges after rstb rises.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    sync_fifo #(
        .BITLEN (BITLEN),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstb     (rst_int_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (pop),
        .ovf_clr  (ovf_clr),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        rdy_d     = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = head;
                    rdy_d     = 1'b1;
                    state_d   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rdy_q     <= rdy_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter that records launched words.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rstb;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       ovf_clr;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_data_ready;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] rx_q[$];
    bit         stall = 1'b0;
    int         busy_len = 50;

    uart_tx_fifo #(.BITLEN(8), .DEPTH(16)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .ovf_clr       (ovf_clr),
        .tx_busy       (tx_busy),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: busy rises one cycle after the strobe, lasts busy_len cycles or while stalled.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_ready === 1'b1) begin
                rx_q.push_back(tx_data);
                @(posedge clk);
                #1 tx_busy = 1'b1;
                for (int c = 0; stall || c < busy_len; c++) begin
                    @(posedge clk);
                    #1;
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [7:0] d, input logic clr);
        wr_data = d;
        wr_en   = 1'b1;
        ovf_clr = clr;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset;
        rstb = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        n_total++; if (level !== 5'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else n_pass++;
        n_total++; if (tx_data_ready !== 1'b0) $display("FAIL rst_rdy: got %b want 0", tx_data_ready); else n_pass++;
        n_total++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %h want 00", tx_data); else n_pass++;
        @(posedge clk);
        #1 rstb = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int pulses = 0;
        int busy_cyc = 0;
        int bad = 0;
        stall = 1'b0; busy_len = 50;
        rx_q.delete();
        wr(8'hA5, 1'b0);
        @(negedge clk);
        n_total++; if (level !== 5'd1) $display("FAIL single_level1: got %0d want 1", level); else n_pass++;
        n_total++; if (tx_data_ready !== 1'b0) $display("FAIL single_early_rdy: got %b want 0", tx_data_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (tx_data_ready !== 1'b1) $display("FAIL single_rdy: got %b want 1", tx_data_ready); else n_pass++;
        n_total++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", tx_data); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty); else n_pass++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_data_ready === 1'b1) pulses++;
            if (tx_busy) begin
                busy_cyc++;
                if (tx_data !== 8'hA5) bad++;
            end else if (busy_cyc > 0) begin
                break;
            end
        end
        n_total++; if (busy_cyc != 50) $display("FAIL single_busy_len: got %0d want 50", busy_cyc); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL single_hold: got %0d unstable cycles want 0", bad); else n_pass++;
        n_total++; if (pulses != 0) $display("FAIL single_extra_pulse: got %0d want 0", pulses); else n_pass++;
        n_total++; if (rx_q.size() != 1) $display("FAIL single_count: got %0d want 1", rx_q.size()); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_overflow;
        stall = 1'b1; busy_len = 3;
        rx_q.delete();
        for (int i = 0; i < 17; i++) wr(8'(i), 1'b0);
        @(negedge clk);
        n_total++; if (level !== 5'd16) $display("FAIL ovf_level_full: got %0d want 16", level); else n_pass++;
        n_total++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_pre: got %b want 0", overflow); else n_pass++;
        @(posedge clk); #1;
        wr(8'hFF, 1'b0);
        @(negedge clk);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
        n_total++; if (level !== 5'd16) $display("FAIL ovf_level_after_drop: got %0d want 16", level); else n_pass++;
        @(posedge clk); #1;
        wr(8'hEE, 1'b1);
        @(negedge clk);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_clr_vs_set: got %b want 1", overflow); else n_pass++;
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b want 0", overflow); else n_pass++;
        stall = 1'b0;
        for (int i = 0; i < 3000 && !(rx_q.size() == 17 && !tx_busy && empty); i++) @(negedge clk);
        n_total++; if (rx_q.size() != 17) $display("FAIL ovf_count: got %0d want 17", rx_q.size()); else n_pass++;
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            n_total++; if (rx_q[i] !== 8'(i)) $display("FAIL ovf_order[%0d]: got %h want %h", i, rx_q[i], 8'(i)); else n_pass++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_simul_wr_pop;
        bit seen_low = 1'b0;
        stall = 1'b1; busy_len = 3;
        rx_q.delete();
        wr(8'h20, 1'b0); wr(8'h21, 1'b0); wr(8'h22, 1'b0); wr(8'h23, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (level !== 5'd3) $display("FAIL simul_pre_level: got %0d want 3", level); else n_pass++;
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx_busy) begin seen_low = 1'b1; break; end
        end
        n_total++; if (!seen_low) $display("FAIL simul_busy_fall: got busy=%b want 0", tx_busy); else n_pass++;
        @(posedge clk); #1;
        wr(8'h24, 1'b0);
        @(negedge clk);
        n_total++; if (tx_data_ready !== 1'b1) $display("FAIL simul_pop_strobe: got %b want 1", tx_data_ready); else n_pass++;
        n_total++; if (level !== 5'd3) $display("FAIL simul_level: got %0d want 3", level); else n_pass++;
        for (int i = 0; i < 500 && !(rx_q.size() == 5 && !tx_busy && empty); i++) @(negedge clk);
        n_total++; if (rx_q.size() != 5) $display("FAIL simul_count: got %0d want 5", rx_q.size()); else n_pass++;
        if (rx_q.size() == 5) begin
            n_total++; if (rx_q[1] !== 8'h21) $display("FAIL simul_first_after: got %h want 21", rx_q[1]); else n_pass++;
            n_total++; if (rx_q[4] !== 8'h24) $display("FAIL simul_fourth: got %h want 24", rx_q[4]); else n_pass++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_wrap;
        stall = 1'b0; busy_len = 2;
        rx_q.delete();
        for (int i = 0; i < 20; i++) wr(8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 3000 && !(rx_q.size() == 20 && !tx_busy && empty); i++) @(negedge clk);
        n_total++; if (rx_q.size() != 20) $display("FAIL wrap_count: got %0d want 20", rx_q.size()); else n_pass++;
        for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
            n_total++; if (rx_q[i] !== 8'h40 + 8'(i)) $display("FAIL wrap_order[%0d]: got %h want %h", i, rx_q[i], 8'h40 + 8'(i)); else n_pass++;
        end
        n_total++; if (overflow !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", overflow); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame;
        int spurious = 0;
        stall = 1'b1; busy_len = 3;
        rx_q.delete();
        for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (level !== 5'd5) $display("FAIL rmid_pre_level: got %0d want 5", level); else n_pass++;
        n_total++; if (tx_busy !== 1'b1) $display("FAIL rmid_in_frame: got busy=%b want 1", tx_busy); else n_pass++;
        rstb = 1'b0;
        @(negedge clk);
        n_total++; if (tx_data_ready !== 1'b0) $display("FAIL rmid_rdy: got %b want 0", tx_data_ready); else n_pass++;
        n_total++; if (level !== 5'd0) $display("FAIL rmid_level: got %0d want 0", level); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL rmid_empty: got %b want 1", empty); else n_pass++;
        @(posedge clk);
        #1 rstb = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_data_ready === 1'b1) spurious++;
        end
        n_total++; if (spurious != 0) $display("FAIL rmid_spurious: got %0d launches want 0", spurious); else n_pass++;
        n_total++; if (rx_q.size() != 1) $display("FAIL rmid_rx_count: got %0d want 1", rx_q.size()); else n_pass++;
        @(posedge clk); #1;
        wr(8'h77, 1'b0);
        @(negedge clk);
        n_total++; if (tx_data_ready !== 1'b0) $display("FAIL rmid_idle_early: got %b want 0", tx_data_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (tx_data_ready !== 1'b1) $display("FAIL rmid_idle_launch: got %b want 1", tx_data_ready); else n_pass++;
        n_total++; if (tx_data !== 8'h77) $display("FAIL rmid_idle_data: got %h want 77", tx_data); else n_pass++;
        for (int i = 0; i < 100 && !(!tx_busy && rx_q.size() == 2); i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        wr_en = 1'b0; ovf_clr = 1'b0; wr_data = 8'h00; rstb = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_simul_wr_pop();
        test_wrap();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
